// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel edge filter.
// Default frame geometry, FSM states and magnitude saturation.
package sobel_pkg;

    localparam int unsigned DEF_IMG_W = 8;
    localparam int unsigned DEF_IMG_H = 8;
    localparam int unsigned N         = DEF_IMG_W * DEF_IMG_H;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } state_t;

    // |gx| + |gy| clipped to the largest pix_w-bit unsigned value.
    function automatic int sat_mag(input int gx, input int gy, input int pix_w);
        int ax;
        int ay;
        int sum;
        int lim;
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        sum = ax + ay;
        lim = (1 << pix_w) - 1;
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel kernel: nine pixels in, saturated edge magnitude out.
// i_win holds p0 in the low PIX_W bits up to p8 in the top PIX_W bits.
module sobel_kernel
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = 8
) (
    input  logic [9*PIX_W-1:0] i_win,
    output logic [PIX_W-1:0]   o_mag
);

    localparam int unsigned AW = PIX_W + 4;

    logic signed [AW-1:0] w_p [9];
    logic signed [AW-1:0] w_gx;
    logic signed [AW-1:0] w_gy;

    always_comb begin
        for (int unsigned i = 0; i < 9; i++) begin
            w_p[i] = $signed({4'b0000, i_win[i*PIX_W +: PIX_W]});
        end
        w_gx  = (w_p[2] + (w_p[5] <<< 1) + w_p[8]) - (w_p[0] + (w_p[3] <<< 1) + w_p[6]);
        w_gy  = (w_p[6] + (w_p[7] <<< 1) + w_p[8]) - (w_p[0] + (w_p[1] <<< 1) + w_p[2]);
        o_mag = PIX_W'(sat_mag(int'(w_gx), int'(w_gy), int'(PIX_W)));
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming Sobel edge-magnitude filter with two-row line buffering
// and valid/ready handshakes on both sides.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_last
);

    // The incoming pixel is used directly as tap p8, so only 2*IMG_W+2 are stored.
    localparam int unsigned SR_LEN = 2 * IMG_W + 2;
    localparam int unsigned CW     = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PIX_W-1:0] r_sr [SR_LEN];
    logic [CW-1:0]    r_irow;
    logic [CW-1:0]    r_icol;
    logic [CW-1:0]    r_orow;
    logic [CW-1:0]    r_ocol;
    logic             r_out_valid;
    logic [PIX_W-1:0] r_out_data;
    logic             r_out_last;

    logic             w_acc;
    logic             w_consume;
    logic             w_gen;
    logic             w_in_last;
    logic             w_border;
    logic             w_out_last;
    logic [PIX_W-1:0] w_mag;
    logic [9*PIX_W-1:0] w_win;

    assign in_ready  = (r_state == FILL) || ((r_state == RUN) && (!r_out_valid || out_ready));
    assign w_acc     = in_valid && in_ready;
    assign w_consume = r_out_valid && out_ready;
    assign w_in_last = (r_irow == CW'(IMG_H - 1)) && (r_icol == CW'(IMG_W - 1));

    assign w_border   = (r_orow == '0) || (r_orow == CW'(IMG_H - 1)) ||
                        (r_ocol == '0) || (r_ocol == CW'(IMG_W - 1));
    assign w_out_last = (r_orow == CW'(IMG_H - 1)) && (r_ocol == CW'(IMG_W - 1));

    assign w_win = {in_data, r_sr[0], r_sr[1],
                    r_sr[IMG_W-1], r_sr[IMG_W], r_sr[IMG_W+1],
                    r_sr[2*IMG_W-1], r_sr[2*IMG_W], r_sr[2*IMG_W+1]};

    sobel_kernel #(
        .PIX_W (PIX_W)
    ) u_kernel (
        .i_win (w_win),
        .o_mag (w_mag)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gen       = 1'b0;
        case (r_state)
            FILL: begin
                if (w_acc && (r_irow == CW'(1)) && (r_icol == '0)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_gen = w_acc;
                if (w_acc && w_in_last) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (w_consume && r_out_last) begin
                    w_state_nxt = FILL;
                end else begin
                    w_gen = !r_out_valid || out_ready;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= FILL;
            r_irow      <= '0;
            r_icol      <= '0;
            r_orow      <= '0;
            r_ocol      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            for (int unsigned i = 0; i < SR_LEN; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;

            if (w_acc) begin
                r_sr[0] <= in_data;
                for (int unsigned i = 1; i < SR_LEN; i++) begin
                    r_sr[i] <= r_sr[i-1];
                end
                if (r_icol == CW'(IMG_W - 1)) begin
                    r_icol <= '0;
                    r_irow <= (r_irow == CW'(IMG_H - 1)) ? '0 : r_irow + 1'b1;
                end else begin
                    r_icol <= r_icol + 1'b1;
                end
            end

            // Output counters track the centre pixel of the next result.
            if (w_gen) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_border ? '0 : w_mag;
                r_out_last  <= w_out_last;
                if (r_ocol == CW'(IMG_W - 1)) begin
                    r_ocol <= '0;
                    r_orow <= (r_orow == CW'(IMG_H - 1)) ? '0 : r_orow + 1'b1;
                end else begin
                    r_ocol <= r_ocol + 1'b1;
                end
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_sobel_stream.sv
// Randomized self-checking bench for sobel_stream against a frame-level Sobel model.
// Two instances: 8x8 for most scenarios, 5x4 for back-to-back frames.
module tb_sobel_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       tb_in_valid;
    logic       tb_out_ready;
    logic [7:0] tb_in_data;

    logic       in_ready0, out_valid0, out_last0;
    logic [7:0] out_data0;
    logic       in_ready1, out_valid1, out_last1;
    logic [7:0] out_data1;

    logic       v_in_ready, v_out_valid, v_out_last;
    logic [7:0] v_out_data;

    int n_checks = 0;
    int n_errors = 0;
    int img [64];
    int exp_q [$];

    always #5 clk = ~clk;

    sobel_stream #(.PIX_W(8), .IMG_W(8), .IMG_H(8)) u_dut0 (
        .clk       (clk),
        .reset_n   (rst_n),
        .in_valid  (tb_in_valid && !sel),
        .in_ready  (in_ready0),
        .in_data   (tb_in_data),
        .out_valid (out_valid0),
        .out_ready (tb_out_ready && !sel),
        .out_data  (out_data0),
        .out_last  (out_last0)
    );

    sobel_stream #(.PIX_W(8), .IMG_W(5), .IMG_H(4)) u_dut1 (
        .clk       (clk),
        .reset_n   (rst_n),
        .in_valid  (tb_in_valid && sel),
        .in_ready  (in_ready1),
        .in_data   (tb_in_data),
        .out_valid (out_valid1),
        .out_ready (tb_out_ready && sel),
        .out_data  (out_data1),
        .out_last  (out_last1)
    );

    assign v_in_ready  = sel ? in_ready1  : in_ready0;
    assign v_out_valid = sel ? out_valid1 : out_valid0;
    assign v_out_last  = sel ? out_last1  : out_last0;
    assign v_out_data  = sel ? out_data1  : out_data0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference Sobel result for centre (r,c) of a w x h frame held in img.
    function automatic int ref_pix(input int w, input int h, input int r, input int c);
        int gx, gy, m;
        if (r == 0 || c == 0 || r == h - 1 || c == w - 1) return 0;
        gx = (img[(r-1)*w+c+1] + 2*img[r*w+c+1] + img[(r+1)*w+c+1])
           - (img[(r-1)*w+c-1] + 2*img[r*w+c-1] + img[(r+1)*w+c-1]);
        gy = (img[(r+1)*w+c-1] + 2*img[(r+1)*w+c] + img[(r+1)*w+c+1])
           - (img[(r-1)*w+c-1] + 2*img[(r-1)*w+c] + img[(r-1)*w+c+1]);
        m = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    // kind 0: uniform 100, 1: horizontal ramp 10*c, 2: vertical step at column 4
    task automatic fill_img(input int kind, input int w, input int h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                case (kind)
                    0:       img[r*w+c] = 100;
                    1:       img[r*w+c] = 10 * c;
                    default: img[r*w+c] = (c < 4) ? 0 : 255;
                endcase
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rst_in_ready0"},  int'(in_ready0),  1);
        check({tag, "_rst_out_valid0"}, int'(out_valid0), 0);
        check({tag, "_rst_out_data0"},  int'(out_data0),  0);
        check({tag, "_rst_out_last0"},  int'(out_last0),  0);
        check({tag, "_rst_in_ready1"},  int'(in_ready1),  1);
        check({tag, "_rst_out_valid1"}, int'(out_valid1), 0);
    endtask

    task automatic run_stream(input string tag, input int w, input int h, input int nfr,
                              input int vpct, input int rpct);
        int   total, in_i, out_i, cyc, held_d, held_l, n_last;
        logic held;
        exp_q.delete();
        for (int f = 0; f < nfr; f++)
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++)
                    exp_q.push_back(ref_pix(w, h, r, c));
        total = w * h * nfr;
        in_i = 0; out_i = 0; cyc = 0; held = 1'b0; held_d = 0; held_l = 0; n_last = 0;
        while (out_i < total && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            tb_out_ready = ($urandom_range(99) < rpct);
            if (in_i < total) begin
                tb_in_valid = ($urandom_range(99) < vpct);
                tb_in_data  = 8'(img[in_i % (w*h)]);
            end else begin
                tb_in_valid = 1'b0;
            end
            #1;
            if (held) begin
                check({tag, "_hold_data"}, int'(v_out_data), held_d);
                check({tag, "_hold_last"}, int'(v_out_last), held_l);
            end
            if (v_out_valid && tb_out_ready) begin
                check($sformatf("%s_data[%0d]", tag, out_i), int'(v_out_data), exp_q[out_i]);
                check($sformatf("%s_last[%0d]", tag, out_i), int'(v_out_last),
                      int'(((out_i + 1) % (w*h)) == 0));
                if (v_out_last) n_last++;
                out_i++;
            end else if (!v_out_valid) begin
                check({tag, "_last_idle"}, int'(v_out_last), 0);
            end
            held   = v_out_valid && !tb_out_ready;
            held_d = int'(v_out_data);
            held_l = int'(v_out_last);
            if (tb_in_valid && v_in_ready) in_i++;
        end
        check({tag, "_outputs"}, out_i, total);
        check({tag, "_inputs"}, in_i, total);
        check({tag, "_n_last"}, n_last, nfr);
        tb_in_valid  = 1'b0;
        tb_out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_no_extra"}, int'(v_out_valid), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        tb_in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("mid");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int cnt, cyc, saw_last;
        sel = 1'b0;
        rst_n = 1'b0;
        tb_in_valid = 1'b0;
        tb_out_ready = 1'b0;
        tb_in_data = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("init");
        rst_n = 1'b1;
        @(negedge clk);

        fill_img(0, 8, 8);
        run_stream("uniform", 8, 8, 1, 100, 100);
        fill_img(1, 8, 8);
        run_stream("ramp", 8, 8, 1, 100, 100);
        fill_img(2, 8, 8);
        run_stream("step", 8, 8, 1, 100, 100);
        fill_img(1, 8, 8);
        run_stream("ramp_stall", 8, 8, 1, 70, 60);
        fill_img(2, 8, 8);
        run_stream("step_stall", 8, 8, 1, 50, 40);

        // Abort a frame after 30 accepted inputs, then a clean uniform frame.
        fill_img(0, 8, 8);
        cnt = 0; cyc = 0; saw_last = 0;
        while (cnt < 30 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            tb_in_valid  = 1'b1;
            tb_in_data   = 8'(img[cnt]);
            tb_out_ready = 1'b1;
            #1;
            if (v_out_valid && v_out_last) saw_last = 1;
            if (v_in_ready) cnt++;
        end
        check("partial_inputs", cnt, 30);
        check("partial_no_last", saw_last, 0);
        pulse_reset();
        run_stream("after_reset", 8, 8, 1, 100, 100);

        sel = 1'b1;
        fill_img(1, 5, 4);
        run_stream("b2b_5x4", 5, 4, 2, 100, 100);
        run_stream("b2b_5x4_stall", 5, 4, 2, 60, 50);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
